// File: rtl/gray_pkg.sv
// Shared constants and pixel helpers for the grayscale datapath.
// Holds the default luma weights, the 0x00RRGGBB field layout and the rounding term.
package gray_pkg;

  localparam logic [7:0] R_COEF_DEFAULT = 8'd77;
  localparam logic [7:0] G_COEF_DEFAULT = 8'd150;
  localparam logic [7:0] B_COEF_DEFAULT = 8'd29;
  localparam int         COEF_SUM       = 256;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;
  localparam int PIX_W = 24;

  localparam logic [15:0] ROUND_CONST = 16'd128;

  localparam int GRAY_W = 8;
  localparam int WORD_W = 32;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t split_pixel(input logic [PIX_W-1:0] pix);
    rgb_t c;
    c.r = pix[R_MSB:R_LSB];
    c.g = pix[G_MSB:G_LSB];
    c.b = pix[B_MSB:B_LSB];
    return c;
  endfunction

  function automatic logic [15:0] weigh(input logic [7:0] coef, input logic [7:0] chan);
    return 16'(coef) * 16'(chan);
  endfunction

endpackage

// File: rtl/gray_pack.sv
// Output register stage of the grayscale pipeline, optionally packing four gray bytes per word.
// Build option: define GRAY_PACK_EN to pack; otherwise one zero-extended word per pixel.
module gray_pack
  import gray_pkg::*;
(
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [GRAY_W-1:0]   in_gray,
  input  logic                out_full_n,
  output logic                out_write,
  output logic [WORD_W-1:0]   out_data,
  output logic                busy
);

`ifdef GRAY_PACK_EN

  logic [1:0]          byte_cnt;
  logic [23:0]         acc;
  logic                out_valid;
  logic [WORD_W-1:0]   out_word;
  logic                out_slot_free;
  logic                accept;
  logic                last_byte;

  assign out_slot_free = !out_valid || out_full_n;
  assign last_byte     = (byte_cnt == 2'd3);
  // Only the fourth byte needs the output slot; earlier bytes land in the accumulator.
  assign in_ready      = !last_byte || out_slot_free;
  assign accept        = in_valid && in_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      byte_cnt  <= 2'd0;
      acc       <= 24'h0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      if (accept && last_byte) begin
        out_word  <= {in_gray, acc};
        out_valid <= 1'b1;
      end else if (out_full_n) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    acc[7:0]   <= in_gray;
          2'd1:    acc[15:8]  <= in_gray;
          2'd2:    acc[23:16] <= in_gray;
          default: acc        <= 24'h0;
        endcase
      end
    end
  end

  assign out_write = out_valid && out_full_n;
  assign out_data  = out_word;
  // A partially filled word still counts as work in flight.
  assign busy      = out_valid || (byte_cnt != 2'd0);

`else

  logic              out_valid;
  logic [GRAY_W-1:0] out_gray;

  assign in_ready = !out_valid || out_full_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_gray  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_gray <= in_gray;
      end
    end
  end

  assign out_write = out_valid && out_full_n;
  assign out_data  = {{(WORD_W-GRAY_W){1'b0}}, out_gray};
  assign busy      = out_valid;

`endif

endmodule

// File: rtl/grayscale_core.sv
// RGB to 8-bit gray converter: weighted sum of channels with rounding, three-stage elastic pipeline.
// Build option: GRAY_PACK_EN packs four gray results per output word (see gray_pack).
module grayscale_core
  import gray_pkg::*;
#(
  parameter logic [7:0] R_COEF = R_COEF_DEFAULT,
  parameter logic [7:0] G_COEF = G_COEF_DEFAULT,
  parameter logic [7:0] B_COEF = B_COEF_DEFAULT
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [31:0]       in_r_dout,
  input  logic              in_r_empty_n,
  output logic              in_r_read,
  output logic [31:0]       out_r_din,
  input  logic              out_r_full_n,
  output logic              out_r_write,
  output logic              ap_idle
);

  localparam int COEF_TOTAL = int'(R_COEF) + int'(G_COEF) + int'(B_COEF);

  // Weights must sum to 256 so the >>8 normalisation keeps white at 255.
  generate
    if (COEF_TOTAL != COEF_SUM) begin : g_bad_coef
      $error("grayscale_core: R_COEF+G_COEF+B_COEF must equal 256");
    end
  endgenerate

  rgb_t              px;
  logic              unused_upper_byte;

  logic              s1_valid;
  logic [15:0]       s1_r_prod;
  logic [15:0]       s1_g_prod;
  logic [15:0]       s1_b_prod;
  logic              s1_ready;

  logic [15:0]       sum_rounded;
  logic [GRAY_W-1:0] gray_d;

  logic              s2_valid;
  logic [GRAY_W-1:0] s2_gray;
  logic              s2_ready;

  logic              pack_ready;
  logic              pack_busy;

  assign px                = split_pixel(in_r_dout[PIX_W-1:0]);
  assign unused_upper_byte = ^in_r_dout[31:PIX_W];

  assign s2_ready  = !s2_valid || pack_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_r_read = ap_rst_n && in_r_empty_n && s1_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid  <= 1'b0;
      s1_r_prod <= '0;
      s1_g_prod <= '0;
      s1_b_prod <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_r_read;
      if (in_r_read) begin
        s1_r_prod <= weigh(R_COEF, px.r);
        s1_g_prod <= weigh(G_COEF, px.g);
        s1_b_prod <= weigh(B_COEF, px.b);
      end
    end
  end

  // Max sum is 255*256+128, so 16 bits never overflow.
  assign sum_rounded = s1_r_prod + s1_g_prod + s1_b_prod + ROUND_CONST;
  assign gray_d      = GRAY_W'(sum_rounded >> 8);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid <= 1'b0;
      s2_gray  <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_gray <= gray_d;
      end
    end
  end

  gray_pack u_pack (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (s2_valid),
    .in_ready   (pack_ready),
    .in_gray    (s2_gray),
    .out_full_n (out_r_full_n),
    .out_write  (out_r_write),
    .out_data   (out_r_din),
    .busy       (pack_busy)
  );

  assign ap_idle = !(s1_valid || s2_valid || pack_busy);

endmodule

// File: tb/tb_grayscale_core.sv
// Self-checking bench for grayscale_core against an arithmetic luma model.
// Honours GRAY_PACK_EN the same way the design does.
module tb_grayscale_core;

`ifdef GRAY_PACK_EN
  localparam bit PACK_MODE = 1'b1;
`else
  localparam bit PACK_MODE = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] in_r_dout;
  logic        in_r_empty_n;
  logic        in_r_read;
  logic [31:0] out_r_din;
  logic        out_r_full_n;
  logic        out_r_write;
  logic        ap_idle;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  pend_q[$];

  always #5 ap_clk = ~ap_clk;

  grayscale_core dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .in_r_dout    (in_r_dout),
    .in_r_empty_n (in_r_empty_n),
    .in_r_read    (in_r_read),
    .out_r_din    (out_r_din),
    .out_r_full_n (out_r_full_n),
    .out_r_write  (out_r_write),
    .ap_idle      (ap_idle)
  );

  // Luma from plain integer arithmetic on the three channels.
  function automatic logic [7:0] gray_model(input logic [31:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return 8'((77 * r + 150 * g + 29 * b + 128) / 256);
  endfunction

  task automatic model_push(input logic [31:0] p);
`ifdef GRAY_PACK_EN
    pend_q.push_back(gray_model(p));
    if (pend_q.size() == 4) begin
      exp_q.push_back({pend_q[3], pend_q[2], pend_q[1], pend_q[0]});
      pend_q.delete();
    end
`else
    exp_q.push_back({24'h0, gray_model(p)});
`endif
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
  endtask

  task automatic run_cycle(input logic en, input logic [31:0] pix, input logic fulln,
                           output logic rd, output logic wr, output logic [31:0] dout);
    @(negedge ap_clk);
    in_r_empty_n = en;
    in_r_dout    = pix;
    out_r_full_n = fulln;
    #1;
    rd   = in_r_read;
    wr   = out_r_write;
    dout = out_r_din;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n     = 1'b0;
    in_r_empty_n = 1'b0;
    out_r_full_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    in_r_empty_n = 1'b1;
    in_r_dout    = 32'h00FFFFFF;
    out_r_full_n = 1'b1;
    ap_rst_n     = 1'b1;
    #2 ap_rst_n  = 1'b0;
    repeat (3) @(negedge ap_clk);
    #1;
    checks++;
    if (in_r_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read got=%b expected=0", in_r_read); end
    checks++;
    if (out_r_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write got=%b expected=0", out_r_write); end
    checks++;
    if (ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle got=%b expected=1", ap_idle); end
    checks++;
    if (out_r_din !== 32'h0) begin errors++; $display("[TB] FAIL reset_dout got=%h expected=00000000", out_r_din); end
    @(negedge ap_clk);
    in_r_empty_n = 1'b0;
    ap_rst_n     = 1'b1;
    model_clear();
  endtask

  task automatic test_vectors();
    logic [31:0] vec[5];
    logic [31:0] exp_words[5];
    logic        rd, wr;
    logic [31:0] dout;
    int idx = 0, rd_cnt = 0, wr_cnt = 0, lat_rd = -1, lat_wr = -1;
    int n_exp;
    vec = '{32'h00FFFFFF, 32'h00FF0000, 32'h0000FF00, 32'h000000FF, 32'h00000000};
    if (PACK_MODE) begin
      exp_words = '{32'h1D954DFF, 32'h0, 32'h0, 32'h0, 32'h0};
      n_exp = 1;
    end else begin
      exp_words = '{32'hFF, 32'h4D, 32'h95, 32'h1D, 32'h00};
      n_exp = 5;
    end
    do_reset();
    for (int c = 0; c < 30; c++) begin
      run_cycle(idx < 5, (idx < 5) ? vec[idx] : 32'h0, 1'b1, rd, wr, dout);
      if (rd) begin
        model_push(vec[idx]);
        idx++;
        rd_cnt++;
        if (rd_cnt == (PACK_MODE ? 4 : 1)) lat_rd = c;
      end
      if (wr) begin
        if (lat_wr < 0) lat_wr = c;
        checks++;
        if (wr_cnt >= n_exp) begin
          errors++;
          $display("[TB] FAIL vec_extra_write got=%h expected=none", dout);
        end else if (dout !== exp_words[wr_cnt]) begin
          errors++;
          $display("[TB] FAIL vec_word%0d got=%h expected=%h", wr_cnt, dout, exp_words[wr_cnt]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        wr_cnt++;
      end
    end
    checks++;
    if (wr_cnt != n_exp) begin errors++; $display("[TB] FAIL vec_count got=%0d expected=%0d", wr_cnt, n_exp); end
    checks++;
    if (lat_wr - lat_rd != 3) begin
      errors++;
      $display("[TB] FAIL vec_latency got=%0d expected=3", lat_wr - lat_rd);
    end
    checks++;
    if (ap_idle !== !PACK_MODE) begin
      errors++;
      $display("[TB] FAIL vec_idle got=%b expected=%b", ap_idle, !PACK_MODE);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pix[10];
    logic        rd, wr, en, fulln, saw_drop;
    logic [31:0] dout, expw;
    int idx = 0, rd_cnt = 0, wr_cnt = 0, drop_buf = -1, spurious = 0;
    saw_drop = 1'b0;
    for (int i = 0; i < 10; i++) pix[i] = $urandom;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      en    = (idx < 10);
      fulln = !(c >= 4 && c <= 8);
      run_cycle(en, en ? pix[idx] : 32'h0, fulln, rd, wr, dout);
      if (rd) begin
        model_push(pix[idx]);
        idx++;
        rd_cnt++;
      end
      if (wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          spurious++;
        end else begin
          expw = exp_q.pop_front();
          checks++;
          if (dout !== expw) begin
            errors++;
            $display("[TB] FAIL bp_word%0d got=%h expected=%h", wr_cnt - 1, dout, expw);
          end
        end
      end
      if (en && !fulln && !rd && !saw_drop) begin
        saw_drop = 1'b1;
        drop_buf = rd_cnt - wr_cnt;
      end
    end
`ifndef GRAY_PACK_EN
    checks++;
    if (!saw_drop || drop_buf != 3) begin
      errors++;
      $display("[TB] FAIL bp_read_drop got=%0d buffered expected=3", drop_buf);
    end
`endif
    checks++;
    if (idx != 10) begin errors++; $display("[TB] FAIL bp_reads got=%0d expected=10", idx); end
    checks++;
    if (exp_q.size() != 0 || spurious != 0) begin
      errors++;
      $display("[TB] FAIL bp_drain got=%0d pending %0d spurious expected=0 0", exp_q.size(), spurious);
    end
  endtask

  task automatic test_toggle();
    logic [31:0] pix[8];
    logic        rd, wr, en;
    logic [31:0] dout, expw;
    int idx = 0, wr_cnt = 0, bad_rd = 0, spurious = 0;
    int exp_writes;
    exp_writes = PACK_MODE ? 2 : 8;
    for (int i = 0; i < 8; i++) pix[i] = $urandom;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      en = (idx < 8) && (c % 2 == 0);
      run_cycle(en, en ? pix[idx] : 32'hDEADBEEF, 1'b1, rd, wr, dout);
      if (rd && !en) bad_rd++;
      if (rd && en) begin
        model_push(pix[idx]);
        idx++;
      end
      if (wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          spurious++;
        end else begin
          expw = exp_q.pop_front();
          checks++;
          if (dout !== expw) begin
            errors++;
            $display("[TB] FAIL tog_word%0d got=%h expected=%h", wr_cnt - 1, dout, expw);
          end
        end
      end
    end
    checks++;
    if (bad_rd != 0) begin errors++; $display("[TB] FAIL tog_read_when_empty got=%0d expected=0", bad_rd); end
    checks++;
    if (wr_cnt != exp_writes || spurious != 0) begin
      errors++;
      $display("[TB] FAIL tog_count got=%0d writes %0d spurious expected=%0d 0", wr_cnt, spurious, exp_writes);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] pix[3];
    logic        rd, wr, first_rd;
    logic [31:0] dout, expw;
    int idx = 0, wr_cnt = 0, spurious = 0, rst_wr = 0;
    int exp_writes;
    exp_writes = PACK_MODE ? 0 : 3;
    for (int i = 0; i < 3; i++) pix[i] = $urandom;
    do_reset();
    run_cycle(1'b1, $urandom, 1'b1, rd, wr, dout);
    run_cycle(1'b1, $urandom, 1'b1, rd, wr, dout);
    @(negedge ap_clk);
    in_r_empty_n = 1'b0;
    ap_rst_n     = 1'b0;
    #1;
    checks++;
    if (ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_idle got=%b expected=1", ap_idle); end
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      #1;
      if (out_r_write !== 1'b0) rst_wr++;
    end
    checks++;
    if (rst_wr != 0) begin errors++; $display("[TB] FAIL mid_rst_write got=%0d expected=0", rst_wr); end
    ap_rst_n = 1'b1;
    model_clear();
    run_cycle(1'b1, pix[0], 1'b1, first_rd, wr, dout);
    if (wr) spurious++;
    checks++;
    if (first_rd !== 1'b1) begin errors++; $display("[TB] FAIL mid_first_read got=%b expected=1", first_rd); end
    if (first_rd) begin
      model_push(pix[0]);
      idx = 1;
    end
    for (int c = 0; c < 30; c++) begin
      run_cycle(idx < 3, (idx < 3) ? pix[idx] : 32'h0, 1'b1, rd, wr, dout);
      if (rd) begin
        model_push(pix[idx]);
        idx++;
      end
      if (wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          spurious++;
        end else begin
          expw = exp_q.pop_front();
          checks++;
          if (dout !== expw) begin
            errors++;
            $display("[TB] FAIL mid_word%0d got=%h expected=%h", wr_cnt - 1, dout, expw);
          end
        end
      end
    end
    checks++;
    if (wr_cnt != exp_writes || spurious != 0) begin
      errors++;
      $display("[TB] FAIL mid_count got=%0d writes %0d spurious expected=%0d 0", wr_cnt, spurious, exp_writes);
    end
  endtask

  task automatic test_upper_byte();
    logic [31:0] pix[4];
    logic [31:0] outs[4];
    logic        rd, wr;
    logic [31:0] dout, expw;
    int idx = 0, wr_cnt = 0;
    pix = '{32'hAB123456, 32'h00123456, 32'hFF123456, 32'h00123456};
    do_reset();
    for (int c = 0; c < 30; c++) begin
      run_cycle(idx < 4, (idx < 4) ? pix[idx] : 32'h0, 1'b1, rd, wr, dout);
      if (rd) begin
        model_push(pix[idx]);
        idx++;
      end
      if (wr) begin
        if (wr_cnt < 4) outs[wr_cnt] = dout;
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL ub_extra_write got=%h expected=none", dout);
        end else begin
          expw = exp_q.pop_front();
          if (dout !== expw) begin
            errors++;
            $display("[TB] FAIL ub_word%0d got=%h expected=%h", wr_cnt - 1, dout, expw);
          end
        end
      end
    end
    checks++;
    if (wr_cnt != (PACK_MODE ? 1 : 4)) begin
      errors++;
      $display("[TB] FAIL ub_count got=%0d expected=%0d", wr_cnt, PACK_MODE ? 1 : 4);
    end else begin
`ifdef GRAY_PACK_EN
      checks++;
      if (outs[0][7:0] !== outs[0][15:8]) begin
        errors++;
        $display("[TB] FAIL ub_same got=%h expected=%h", outs[0][7:0], outs[0][15:8]);
      end
`else
      checks++;
      if (outs[0] !== outs[1]) begin
        errors++;
        $display("[TB] FAIL ub_same got=%h expected=%h", outs[0], outs[1]);
      end
`endif
    end
  endtask

  initial begin
    in_r_dout    = 32'h0;
    in_r_empty_n = 1'b0;
    out_r_full_n = 1'b1;
    ap_rst_n     = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_toggle();
    test_reset_midstream();
    test_upper_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grayscale_core.md
GRAYSCALE_CORE -- requirements
Module: grayscale_core

Interface
REQ-001 R_COEF, 77, red weight (unsigned 8-bit).
REQ-002 G_COEF, 150, green weight (unsigned 8-bit).
REQ-003 B_COEF, 29, blue weight (unsigned 8-bit); R_COEF+G_COEF+B_COEF SHALL equal 256, checked at elaboration.
REQ-004 ap_clk  in  1  the only clock; all logic on its rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_r_dout  in  32  input pixel 0x00RRGGBB; bits [31:24] ignored.
REQ-007 in_r_empty_n  in  1  in_r_dout valid (first-word-fall-through source).
REQ-008 in_r_read  out  1  consume in_r_dout this cycle.
REQ-009 out_r_din  out  32  output word.
REQ-010 out_r_full_n  in  1  sink can accept a word.
REQ-011 out_r_write  out  1  out_r_din is written this cycle.
REQ-012 ap_idle  out  1  high when no pixel is in flight, including any partial pack.

Function
REQ-013 gray SHALL be (R_COEF*R + G_COEF*G + B_COEF*B + 128) >> 8, with a 16-bit intermediate and an 8-bit result, no saturation needed.
REQ-014 Pipeline SHALL be S1 (register the three products), S2 (register sum and rounded result), OUT (output register); each stage has a valid bit.
REQ-015 in_r_read SHALL be in_r_empty_n AND S1-can-advance, driven combinationally; no read while in_r_empty_n is low.
REQ-016 A stage SHALL advance when the next stage is empty or advancing, so the pipeline forms a fully stalled chain with no bubbles inserted.
REQ-017 out_r_write SHALL be OUT-valid AND out_r_full_n; OUT SHALL hold its value while out_r_full_n is low.
REQ-018 Latency SHALL be 3 cycles: a pixel read at edge N appears with out_r_write at cycle N+3 when unstalled.
REQ-019 Throughput SHALL be 1 pixel per cycle under continuous input and no backpressure.
REQ-020 Pixel order SHALL be preserved, with no loss or duplication under any in_r_empty_n / out_r_full_n pattern.
REQ-021 Simultaneous read and write in one cycle SHALL be supported.

Reset
REQ-022 While ap_rst_n is low: all valid bits, the pack counter and out_r_din SHALL be 0, in_r_read and out_r_write SHALL be 0, and ap_idle SHALL be 1.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight pixels immediately; the first read after release SHALL be the current in_r_dout.

Configuration
REQ-024 Macro GRAY_PACK_EN.
- Defined: four consecutive gray values SHALL be packed into one word, first pixel in byte 0. OUT SHALL become valid only on the 4th pixel. A partial pack SHALL be held indefinitely and cleared only by reset. Latency from the 4th pixel SHALL be 3 cycles.
- Undefined: one word per pixel, out_r_din = {24'h0, gray}.

Structure
REQ-025 Package gray_pkg SHALL hold the default coefficients, the pixel field offsets (R 23:16, G 15:8, B 7:0) and the rounding constant 128.
REQ-026 The OUT stage and the packing logic SHALL live in sub-module gray_pack (byte accumulator, 2-bit counter, output register); without GRAY_PACK_EN it degenerates to a single register stage.

Verification
REQ-027 Without pack: inputs 0x00FFFFFF, 0x00FF0000, 0x0000FF00, 0x000000FF, 0x00000000 -> outputs 0xFF, 0x4D, 0x95, 0x1D, 0x00 in order, first write 3 cycles after the first read.
REQ-028 With GRAY_PACK_EN: the same first four inputs -> a single word 0x1D954DFF; the 5th input alone -> no write and ap_idle=0.
REQ-029 Stream 10 random pixels, out_r_full_n low for cycles 4-8 -> in_r_read drops once 3 pixels are buffered; all 10 outputs match the model in order.
REQ-030 in_r_empty_n toggling every cycle with out_r_full_n=1 -> one output per input, no spurious out_r_write.
REQ-031 ap_rst_n pulsed low with 2 pixels in flight -> out_r_write stays 0; the next 3 inputs produce exactly 3 correct outputs.
REQ-032 Input 0xAB123456 -> result equals that of 0x00123456 (upper byte ignored).
